// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI controller.
package jstk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SS_SETUP,
    SHIFT,
    BYTE_GAP,
    FINISH
  } jstk_state_e;

  localparam int         NUM_BYTES  = 5;
  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  // Byte positions within a transfer, in wire order (b0 first).
  localparam int X_LO_IDX = 0;
  localparam int X_HI_IDX = 1;
  localparam int Y_LO_IDX = 2;
  localparam int Y_HI_IDX = 3;
  localparam int BTN_IDX  = 4;

  // The receive buffer is packed with b0 in the top slot so it maps straight onto DOUT.
  function automatic int slot_of(input int idx);
    return NUM_BYTES - 1 - idx;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// 8-bit SPI mode-0 shift engine: runs while en is high, pulses done on the 8th SCLK fall.
module jstk_spi_byte
  import jstk_pkg::*;
#(
  parameter int CLKS_PER_HALF = 750
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);

  localparam int            HW        = cnt_w(CLKS_PER_HALF);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF - 1);

  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx;
  logic          tick, fall;

  assign tick = en && (half_cnt == HALF_LAST);
  assign fall = tick && sclk;
  assign done = fall && (bit_cnt == 3'd7);
  assign mosi = tx[7];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      rx       <= '0;
      tx       <= '0;
    end else begin
      if (!en) begin
        half_cnt <= '0;
        bit_cnt  <= '0;
        sclk     <= 1'b0;
      end else if (tick) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
        if (sclk) bit_cnt <= bit_cnt + 1'b1;
        else      rx      <= {rx[6:0], miso};
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end

      // A load on the last fall takes priority over the shift for the next byte.
      if (load)              tx <= load_data;
      else if (fall && !done) tx <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK SPI master: one 5-byte transfer per SNDREC rising edge, results held until the next DONE.
module jstk_spi_ctrl
  import jstk_pkg::*;
#(
  parameter int CLKS_PER_HALF = 750,
  parameter int SS_SETUP_CYC  = 1500,
  parameter int BYTE_GAP_CYC  = 1000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SNDREC,
  input  logic [1:0]  LED,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic        DONE,
  output logic [39:0] DOUT,
  output logic [9:0]  X_POS,
  output logic [9:0]  Y_POS,
  output logic [2:0]  BUTTONS
);

  localparam int            WMAX       = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int            WW         = cnt_w(WMAX);
  localparam logic [WW-1:0] SETUP_LAST = WW'(SS_SETUP_CYC - 1);
  localparam logic [WW-1:0] GAP_LAST   = WW'(BYTE_GAP_CYC - 1);
  localparam int            BW         = cnt_w(NUM_BYTES);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(NUM_BYTES - 1);
  localparam int            XL = slot_of(X_LO_IDX);
  localparam int            XH = slot_of(X_HI_IDX);
  localparam int            YL = slot_of(Y_LO_IDX);
  localparam int            YH = slot_of(Y_HI_IDX);
  localparam int            BT = slot_of(BTN_IDX);

  jstk_state_e               state, state_nxt;
  logic                      sndrec_q, start, wait_end, byte_done, last_byte, load;
  logic [7:0]                load_data, rx_byte;
  logic [WW-1:0]             wait_cnt;
  logic [BW-1:0]             byte_cnt;
  logic [NUM_BYTES-1:0][7:0] rx_buf;

  assign start     = SNDREC && !sndrec_q && (state == IDLE);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign wait_end  = ((state == SS_SETUP) && (wait_cnt == SETUP_LAST)) ||
                     ((state == BYTE_GAP) && (wait_cnt == GAP_LAST));
  assign load      = start || byte_done;
  assign load_data = start ? {CMD_PREFIX, LED} : 8'h00;

  jstk_spi_byte #(.CLKS_PER_HALF(CLKS_PER_HALF)) u_byte (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .en        (state == SHIFT),
    .load      (load),
    .load_data (load_data),
    .miso      (MISO),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .done      (byte_done),
    .rx        (rx_byte)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)     state_nxt = SS_SETUP;
      SS_SETUP: if (wait_end)  state_nxt = SHIFT;
      SHIFT:    if (byte_done) state_nxt = last_byte ? FINISH : BYTE_GAP;
      BYTE_GAP: if (wait_end)  state_nxt = SHIFT;
      FINISH:                  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sndrec_q <= 1'b0;
      SS       <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      wait_cnt <= '0;
      byte_cnt <= '0;
      rx_buf   <= '0;
      DOUT     <= '0;
      X_POS    <= '0;
      Y_POS    <= '0;
      BUTTONS  <= '0;
    end else begin
      sndrec_q <= SNDREC;
      DONE     <= 1'b0;

      if (state_nxt != state)                         wait_cnt <= '0;
      else if ((state == SS_SETUP) || (state == BYTE_GAP)) wait_cnt <= wait_cnt + 1'b1;

      if (start) begin
        SS       <= 1'b0;
        BUSY     <= 1'b1;
        byte_cnt <= '0;
      end

      if (byte_done) begin
        rx_buf[LAST_BYTE - byte_cnt] <= rx_byte;
        if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
      end

      // All outputs switch together so consumers never see a mix of old and new samples.
      if (state == FINISH) begin
        SS      <= 1'b1;
        BUSY    <= 1'b0;
        DONE    <= 1'b1;
        DOUT    <= rx_buf;
        X_POS   <= {rx_buf[XH][1:0], rx_buf[XL]};
        Y_POS   <= {rx_buf[YH][1:0], rx_buf[YL]};
        BUTTONS <= rx_buf[BT][2:0];
      end
    end
  end

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Randomized bench for jstk_spi_ctrl against a cycle-offset reference model.
module tb_jstk_spi_ctrl;

  localparam int H        = 2;
  localparam int SU       = 4;
  localparam int GP       = 3;
  localparam int BYTE_CYC = 16 * H;
  localparam int TOTAL    = SU + 80 * H + 4 * GP + 1;

  logic        CLK = 1'b0, RESET_N = 1'b0, SNDREC = 1'b0, MISO = 1'b0;
  logic [1:0]  LED = 2'b00;
  logic        SS, SCLK, MOSI, BUSY, DONE;
  logic [39:0] DOUT;
  logic [9:0]  X_POS, Y_POS;
  logic [2:0]  BUTTONS;

  int total = 0, bad = 0;
  logic chk_en = 1'b0;

  jstk_spi_ctrl #(.CLKS_PER_HALF(H), .SS_SETUP_CYC(SU), .BYTE_GAP_CYC(GP)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SNDREC(SNDREC), .LED(LED), .MISO(MISO),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .BUSY(BUSY), .DONE(DONE),
    .DOUT(DOUT), .X_POS(X_POS), .Y_POS(Y_POS), .BUTTONS(BUTTONS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Joystick model: first bit ready at SS fall, next bit presented after each SCLK fall.
  logic [39:0] slave_data = '0;
  int sidx = 0;
  always @(negedge SS) begin sidx = 39; MISO = slave_data[39]; end
  always @(negedge SCLK) if (sidx > 0) begin sidx--; MISO = slave_data[sidx]; end

  // Event observers.
  int cyc = 0, rises = 0, falls = 0, ndone = 0;
  int t_ssf = 0, t_rise1 = 0, t_fall8 = 0, t_rise9 = 0, t_done = 0;
  logic [39:0] mosi_cap = '0;
  always @(posedge CLK) cyc++;
  always @(negedge SS) begin t_ssf = cyc; rises = 0; falls = 0; mosi_cap = '0; end
  always @(posedge SCLK) begin
    rises++;
    mosi_cap = {mosi_cap[38:0], MOSI};
    if (rises == 1) t_rise1 = cyc;
    if (rises == 9) t_rise9 = cyc;
  end
  always @(negedge SCLK) begin falls++; if (falls == 8) t_fall8 = cyc; end
  always @(posedge DONE) begin t_done = cyc; ndone++; end

  // Reference model: m_k counts clock edges since the accepted start edge.
  logic        m_busy = 1'b0, m_prev = 1'b0, m_done = 1'b0;
  int          m_k = 0;
  logic [7:0]  m_cmd = '0;
  logic [39:0] m_rx = '0, m_dout = '0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_busy = 1'b0; m_prev = 1'b0; m_done = 1'b0; m_k = 0; m_dout = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == TOTAL) begin m_busy = 1'b0; m_done = 1'b1; m_dout = m_rx; end
      end else if (SNDREC && !m_prev) begin
        m_busy = 1'b1; m_k = 0; m_cmd = {6'b100000, LED}; m_rx = slave_data;
      end
      m_prev = SNDREC;
    end
  end

  function automatic logic exp_sclk(input int k);
    for (int j = 0; j < 5; j++) begin
      int o;
      o = k - (SU + j * (BYTE_CYC + GP));
      if (o >= 0 && o < BYTE_CYC) return ((o / H) % 2) == 1;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_mosi(input int k, input logic [7:0] cmd);
    int b;
    if (k >= SU + BYTE_CYC) return 1'b0;
    b = (k < SU) ? 0 : (k - SU) / (2 * H);
    return cmd[7 - b];
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ss", SS, !m_busy);
      chk("busy", BUSY, m_busy);
      chk("sclk", SCLK, m_busy ? exp_sclk(m_k) : 1'b0);
      chk("mosi", MOSI, m_busy ? exp_mosi(m_k, m_cmd) : 1'b0);
      chk("done", DONE, m_done);
      chk("dout", DOUT, m_dout);
      chk("x_pos", X_POS, {m_dout[25:24], m_dout[39:32]});
      chk("y_pos", Y_POS, {m_dout[9:8], m_dout[23:16]});
      chk("buttons", BUTTONS, m_dout[2:0]);
      if (m_done) begin
        chk("sclk_rises", rises, 40);
        chk("mosi_bytes", mosi_cap, {m_cmd, 32'h0});
      end
    end
  end

  task automatic pulse();
    @(negedge CLK) SNDREC = 1'b1;
    @(negedge CLK) SNDREC = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (DONE !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
    chk(name, DONE, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ss"}, SS, 1'b1);
    chk({tag, "_sclk"}, SCLK, 1'b0);
    chk({tag, "_mosi"}, MOSI, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_dout"}, DOUT, 40'h0);
    chk({tag, "_xyb"}, {X_POS, Y_POS, BUTTONS}, 23'h0);
  endtask

  initial begin
    logic [63:0] r;
    logic [39:0] a;
    int n, n0;

    @(posedge CLK);
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset_state("rst_init");
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Directed transfer with known bytes.
    LED = 2'b01;
    slave_data = 40'hA5023C0305;
    pulse();
    wait_done("t2_done");
    chk("t2_dout", DOUT, 40'hA5023C0305);
    chk("t2_x", X_POS, 10'd677);
    chk("t2_y", Y_POS, 10'd828);
    chk("t2_btn", BUTTONS, 3'b101);
    chk("t2_latency", t_done - t_ssf, 177);
    chk("t3_setup", t_rise1 - t_ssf, 6);
    chk("t3_gap", t_rise9 - t_fall8, 5);
    chk("t3_rises", rises, 40);
    chk("t2_mosi", mosi_cap, 40'h8100000000);
    @(negedge CLK);
    chk("t2_done_width", DONE, 1'b0);
    repeat (5) @(negedge CLK);

    // Edges while busy are dropped; a held-high trigger does not restart.
    LED = 2'b10;
    slave_data = 40'h1122334455;
    n0 = ndone;
    pulse();
    repeat (20) @(negedge CLK);
    SNDREC = 1'b1;
    repeat (10) @(negedge CLK);
    SNDREC = 1'b0;
    repeat (10) @(negedge CLK);
    SNDREC = 1'b1;
    wait_done("t4_done");
    repeat (60) @(negedge CLK);
    chk("t4_one_xfer", ndone - n0, 1);
    chk("t4_idle_ss", SS, 1'b1);
    chk("t4_dout", DOUT, 40'h1122334455);
    SNDREC = 1'b0;
    @(negedge CLK);
    SNDREC = 1'b1;
    wait_done("t4_retrig_done");
    chk("t4_two_xfer", ndone - n0, 2);
    SNDREC = 1'b0;
    repeat (5) @(negedge CLK);

    // Reset in the middle of byte 2, then a clean transfer with fresh data.
    r = {$urandom(), $urandom()};
    slave_data = r[39:0];
    pulse();
    n = 0;
    while (rises < 18 && n < 400) begin @(negedge CLK); n++; end
    chk("t5_in_byte2", (rises >= 18), 1'b1);
    #2 RESET_N = 1'b0;
    #1 chk_reset_state("t5_rst");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    r = {$urandom(), $urandom()};
    slave_data = r[39:0];
    LED = 2'b11;
    pulse();
    wait_done("t5_done");
    chk("t5_dout", DOUT, r[39:0]);
    repeat (4) @(negedge CLK);

    // Back-to-back transfers: old values held until the second DONE.
    r = {$urandom(), $urandom()};
    a = r[39:0];
    slave_data = a;
    pulse();
    wait_done("t6_first_done");
    chk("t6_first", DOUT, a);
    r = {$urandom(), $urandom()};
    slave_data = r[39:0];
    pulse();
    repeat (100) @(negedge CLK);
    chk("t6_hold", DOUT, a);
    wait_done("t6_second_done");
    chk("t6_second", DOUT, r[39:0]);

    // Random transfers; the per-cycle compare does the checking.
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      slave_data = r[39:0];
      LED = 2'($urandom_range(3, 0));
      repeat ($urandom_range(8, 1)) @(negedge CLK);
      pulse();
      wait_done("rand_done");
      chk("rand_dout", DOUT, r[39:0]);
    end
    repeat (5) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
